// File: rtl/mem_port_ctrl_pkg.sv
// Shared encodings for the memory port controller and the control-unit sequencer.
package mem_port_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Wait counter must reach TIMEOUT, so it needs clog2(TIMEOUT+1) bits, never fewer than one.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter: load, synchronous clear, count enable and a terminal flag at LIMIT.
module mem_wait_timer #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             terminal
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // LIMIT of zero means the watchdog is disabled and the flag never fires.
    assign terminal = (LIMIT != 0) && (count_reg == WIDTH'(LIMIT));

endmodule

// File: rtl/mem_port_ctrl.sv
// MAR/MDR pair with a req/ack memory transaction engine, wait-state watchdog and status flags.
module mem_port_ctrl
    import mem_port_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              mar_we,
    input  logic              mdr_we,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              rd_start,
    input  logic              wr_start,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [DATA_W-1:0] mar_reg;
    logic [DATA_W-1:0] mdr_reg;
    state_t            state_reg;
    op_t               op_reg;
    logic              err_reg;
    logic              timer_terminal;
    logic              start_ok;

    assign start_ok = (state_reg == ST_IDLE) && (rd_start ^ wr_start);

    mem_wait_timer #(
        .WIDTH (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (clr),
        .clr      (state_reg == ST_FINISH),
        .load     (start_ok),
        .load_val ('0),
        .en       ((state_reg == ST_ACCESS) && !mem_ack),
        .terminal (timer_terminal)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mar_reg   <= '0;
            mdr_reg   <= '0;
            state_reg <= ST_IDLE;
            op_reg    <= OP_RD;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mar_we) mar_reg <= bus_in;
                    if (mdr_we) mdr_reg <= bus_in;
                    if (rd_start && wr_start) begin
                        err_reg <= 1'b1;
                    end else if (start_ok) begin
                        op_reg    <= wr_start ? OP_WR : OP_RD;
                        err_reg   <= 1'b0;
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // An ack on the terminal cycle still completes the access normally.
                    if (mem_ack) begin
                        if (op_reg == OP_RD) mdr_reg <= mem_rdata;
                        state_reg <= ST_FINISH;
                    end else if (timer_terminal) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_FINISH;
                    end
                end
                ST_FINISH: state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mdr_out   = mdr_reg;
    assign mem_addr  = mar_reg[ADDR_W-1:0];
    assign mem_req   = (state_reg == ST_ACCESS);
    assign mem_we    = mem_req && (op_reg == OP_WR);
    assign mem_wdata = mem_we ? mdr_reg : '0;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_FINISH);
    assign err       = err_reg;

    // Upper MAR bits are kept for the bus side only.
    generate
        if (DATA_W > ADDR_W) begin : g_mar_hi
            logic mar_hi_unused;
            assign mar_hi_unused = ^mar_reg[DATA_W-1:ADDR_W];
        end
    endgenerate

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed + randomized bench for mem_port_ctrl against a transaction-level memory/register model.
module tb_mem_port_ctrl;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              clr;
    logic              mar_we, mdr_we, rd_start, wr_start;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] mdr_out;
    logic              busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_req, mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    mem_port_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .mar_we    (mar_we),
        .mdr_we    (mdr_we),
        .bus_in    (bus_in),
        .rd_start  (rd_start),
        .wr_start  (wr_start),
        .mdr_out   (mdr_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] m_mar, m_mdr;
    logic        m_err;
    logic [31:0] mem_model [0:511];
    int          txn_id = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_load(input bit do_mar, input bit do_mdr, input logic [31:0] mar_v,
                            input logic [31:0] mdr_v);
        mar_we = do_mar;
        mdr_we = do_mdr;
        if (do_mar && do_mdr && mar_v != mdr_v) mdr_v = mar_v;
        bus_in = do_mar ? mar_v : mdr_v;
        if (do_mar) m_mar = bus_in;
        if (do_mdr) m_mdr = bus_in;
    endtask

    // One full transaction: start, req phase with ack after 'waits' idle req cycles, FINISH, IDLE.
    task automatic txn(input bit is_wr, input int waits, input bit poke, input bit b2b);
        int          reqs;
        int          exp_reqs;
        bit          exp_to;
        logic [8:0]  a;
        a        = m_mar[8:0];
        exp_to   = (waits > TIMEOUT);
        exp_reqs = exp_to ? TIMEOUT + 1 : waits + 1;
        if (is_wr) wr_start = 1'b1; else rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0; wr_start = 1'b0; mar_we = 1'b0; mdr_we = 1'b0;
        m_err = 1'b0;
        reqs = 0;
        while (mem_req === 1'b1 && reqs < 40) begin
            reqs++;
            chk("addr", 32'(mem_addr), 32'(a));
            chk("mem_we", 32'(mem_we), 32'(is_wr));
            chk("wdata", mem_wdata, is_wr ? m_mdr : 32'h0);
            chk("busy_acc", 32'(busy), 32'h1);
            mar_we = poke && reqs == 1;
            mdr_we = poke && reqs == 1;
            bus_in = 32'hFFFF_FFFF;
            mem_ack = (reqs == waits + 1);
            mem_rdata = mem_ack ? mem_model[a] : $urandom;
            @(negedge clk);
        end
        mem_ack = 1'b0; mar_we = 1'b0; mdr_we = 1'b0;
        chk("req_cycles", 32'(reqs), 32'(exp_reqs));
        chk("done_pulse", 32'(done), 32'h1);
        chk("busy_fin", 32'(busy), 32'h1);
        if (exp_to)      m_err = 1'b1;
        else if (is_wr)  mem_model[a] = m_mdr;
        else             m_mdr = mem_model[a];
        if (b2b) rd_start = 1'b1;
        @(negedge clk);
        chk("done_low", 32'(done), 32'h0);
        chk("idle_req", 32'(mem_req), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_wdata", mem_wdata, 32'h0);
        chk("mdr", mdr_out, m_mdr);
        chk("err", 32'(err), 32'(m_err));
        $display("txn %0d: %s addr=0x%03h waits=%0d reqs=%0d mdr=0x%08h err=%0b",
                 txn_id, is_wr ? "WR" : "RD", a, waits, reqs, mdr_out, err);
        txn_id++;
    endtask

    initial begin
        clr = 1'b1;
        mar_we = 0; mdr_we = 0; rd_start = 0; wr_start = 0;
        bus_in = '0; mem_rdata = '0; mem_ack = 0;
        m_mar = 0; m_mdr = 0; m_err = 0;
        for (int i = 0; i < 512; i++) mem_model[i] = $urandom;
        mem_model[9'h105] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        chk("rst_mdr", mdr_out, 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        clr = 1'b0;
        @(negedge clk);

        // Zero-wait read
        set_load(1, 0, 32'h0000_0105, 0);
        @(negedge clk); mar_we = 0;
        chk("addr_105", 32'(mem_addr), 32'h105);
        txn(0, 0, 0, 0);
        chk("mdr_beef", mdr_out, 32'hDEAD_BEEF);

        // Write with 3 wait states
        set_load(1, 0, 32'h0000_01FF, 0);
        @(negedge clk);
        set_load(0, 1, 0, 32'h1234_5678);
        @(negedge clk); mdr_we = 0;
        txn(1, 3, 0, 0);
        chk("wr_mem", mem_model[9'h1FF], 32'h1234_5678);

        // Timeout, then err clears on the next legal start
        txn(0, 30, 0, 0);
        chk("to_err", 32'(err), 32'h1);
        txn(0, 2, 0, 0);

        // Illegal start
        rd_start = 1; wr_start = 1;
        @(negedge clk);
        rd_start = 0; wr_start = 0; m_err = 1;
        chk("ill_err", 32'(err), 32'h1);
        chk("ill_req", 32'(mem_req), 32'h0);
        chk("ill_busy", 32'(busy), 32'h0);
        @(negedge clk);
        chk("ill_req2", 32'(mem_req), 32'h0);

        // Ignored register writes during ACCESS
        txn(0, 4, 1, 0);

        // Back-to-back: start in FINISH ignored, start in IDLE accepted
        txn(0, 1, 0, 1);
        txn(0, 0, 0, 0);

        // Async reset in the middle of an access
        set_load(1, 1, 32'h0000_00AB, 32'h0000_00AB);
        @(negedge clk); mar_we = 0; mdr_we = 0;
        rd_start = 1;
        @(negedge clk); rd_start = 0;
        chk("pre_rst_req", 32'(mem_req), 32'h1);
        #2 clr = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_mdr", mdr_out, 32'h0);
        chk("arst_addr", 32'(mem_addr), 32'h0);
        #1 clr = 1'b0;
        m_mar = 0; m_mdr = 0; m_err = 0;
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack = 0;
        chk("late_ack_done", 32'(done), 32'h0);
        chk("late_ack_mdr", mdr_out, 32'h0);
        chk("late_ack_req", 32'(mem_req), 32'h0);

        // Randomized transactions
        begin
            bit force_rd;
            force_rd = 0;
            for (int k = 0; k < 24; k++) begin
                int  mode;
                bit  is_wr;
                bit  b2b;
                mode  = force_rd ? 0 : $urandom_range(0, 2);
                is_wr = force_rd ? 1'b0 : 1'($urandom_range(0, 1));
                b2b   = !force_rd && ($urandom_range(0, 4) == 0);
                if (mode == 1) begin
                    set_load(1, 0, $urandom, 0);
                    @(negedge clk);
                    set_load(0, 1, 0, $urandom);
                    @(negedge clk); mdr_we = 0;
                end else if (mode == 2) begin
                    set_load(1, 0, $urandom, 0);
                end
                txn(is_wr, $urandom_range(0, 18), 1'($urandom_range(0, 1)), b2b);
                force_rd = b2b;
            end
            if (force_rd) txn(0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
Parametrised successor to the single-cycle MAR/MDR pair. It holds the address (MAR) and data (MDR) registers and runs complete memory read/write transactions over a req/ack handshake with variable wait states. It also has a timeout watchdog and busy/done/err status for the control unit. It sits between the CPU internal bus and the memory model.

Parameters:
DATA_W, 32, width of the bus, the MDR and memory data.
ADDR_W, 9, memory address width; the MAR drives its low ADDR_W bits (ADDR_W <= DATA_W).
TIMEOUT, 15, maximum cycles to wait for mem_ack; 0 disables the watchdog.

Ports:
clk  in  1  clock; all state updates on the rising edge.
clr  in  1  reset, asynchronous, active-high.
mar_we  in  1  load MAR from bus_in.
mdr_we  in  1  load MDR from bus_in.
bus_in  in  DATA_W  internal bus data.
rd_start  in  1  start a memory read at MAR into MDR.
wr_start  in  1  start a memory write of MDR to MAR.
mdr_out  out  DATA_W  MDR contents, always driven to the bus mux.
busy  out  1  transaction in progress.
done  out  1  one-cycle completion pulse.
err  out  1  sticky error flag.
mem_addr  out  ADDR_W  MAR[ADDR_W-1:0].
mem_wdata  out  DATA_W  MDR during a write access, else 0.
mem_req  out  1  access request.
mem_we  out  1  1 = write access, 0 = read access; qualified by mem_req.
mem_rdata  in  DATA_W  read data, valid with mem_ack.
mem_ack  in  1  memory completes the access this cycle.

Behaviour:
- Reset (clr=1, asynchronous):
  - MAR=0, MDR=0, state=IDLE, wait counter=0.
  - busy, done, err, mem_req and mem_we are all 0.
  - Reset mid-transaction aborts it immediately. No done pulse is produced.
- FSM states: IDLE, ACCESS, FINISH.
- IDLE:
  - mar_we and mdr_we load their registers on the edge. Both may be asserted together.
  - rd_start=1 alone: latch op=read, go to ACCESS, clear err.
  - wr_start=1 alone: latch op=write, go to ACCESS, clear err.
  - rd_start and wr_start together: illegal. Set err=1, stay IDLE, no memory access.
  - A start in the same cycle as mar_we/mdr_we: the register load and the start happen on the same edge. The access uses the newly loaded value.
- ACCESS:
  - mem_req=1, mem_we=op, busy=1.
  - mem_wdata=MDR when op=write, otherwise 0.
  - mar_we, mdr_we, rd_start and wr_start are all ignored.
  - The wait counter increments every cycle with mem_ack=0.
  - mem_ack=1 on a read: MDR <= mem_rdata, go to FINISH.
  - mem_ack=1 on a write: go to FINISH.
  - Ack in the same cycle the counter reaches TIMEOUT: the ack wins.
  - TIMEOUT!=0 and counter==TIMEOUT without ack: set err=1, MDR unchanged, go to FINISH.
- FINISH:
  - Lasts one cycle.
  - done=1, busy=1, mem_req=0.
  - Clears the counter, then returns to IDLE.
  - A start input in this cycle is ignored.
- Latency:
  - Start sampled at edge n: mem_req is high from cycle n+1.
  - Ack sampled at edge m: done is high in cycle m+1. mdr_out holds read data from cycle m+1.
  - Zero-wait memory (ack in the first req cycle): done appears 2 cycles after the start edge.
- mem_ack while not in ACCESS is ignored.
- err stays 1 until the next legal start or clr.
- mem_addr is always MAR[ADDR_W-1:0]; the upper MAR bits are stored but not driven out.
- All outputs are registered or decoded from state only; there is no combinational path from mem_ack to mem_req.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, FINISH=2'd2) and the op encoding (OP_RD=0, OP_WR=1), reused by the control-unit sequencer.
- Counter width is $clog2(TIMEOUT+1), minimum 1.
- One natural sub-module: mem_wait_timer (loadable counter with clear, enable and terminal flag).
- MAR and MDR stay inline.

Test Plan:
- Read, zero wait:
  - Stimulus: mar_we with bus_in=0x0000_0105; rd_start; memory acks in the first req cycle with 0xDEAD_BEEF.
  - Required: mem_addr=0x105, mem_we=0, done 2 cycles after start, mdr_out=0xDEAD_BEEF, err=0.
- Write, 3 wait states:
  - Stimulus: MAR=0x1FF, MDR=0x1234_5678; wr_start; ack on the 4th req cycle.
  - Required: mem_wdata=0x1234_5678 and mem_req=1 for exactly 4 cycles, one done pulse, mem_wdata=0 afterwards.
- Timeout:
  - Stimulus: TIMEOUT=15, rd_start, never ack.
  - Required: mem_req high 16 cycles, then done=1 with err=1, MDR unchanged; err clears on the next legal start.
- Illegal start and ignored writes:
  - Stimulus: rd_start and wr_start together; later, mdr_we=1 with bus_in=0xFFFF_FFFF during ACCESS.
  - Required: illegal start gives err=1 and no mem_req; the mdr_we during ACCESS leaves MDR unchanged.
- Async reset mid-access:
  - Stimulus: clr pulsed between clock edges during ACCESS.
  - Required: mem_req, busy, done=0 and MAR/MDR=0 immediately, with no done pulse; a later ack is ignored.
- Back-to-back:
  - Stimulus: rd_start asserted in the FINISH cycle, then again in IDLE.
  - Required: the first is ignored; the second starts a new access one cycle later.
